// File: rtl/conv_pkg.sv
// Shared definitions for the convolution pipeline (conv_filter, conv_border_mask).
// Holds the frame geometry defaults, the kernel size default, the packed pixel layout
// and the per-beat sideband tag that travels with each pixel.
package conv_pkg;

    localparam int unsigned PIX_W        = 30;
    localparam int unsigned CH_W         = 10;
    localparam int unsigned SIG_W        = 8;
    localparam int unsigned FRAME_WIDTH  = 320;
    localparam int unsigned FRAME_HEIGHT = 240;
    localparam int unsigned KERNEL_K     = 5;

    // Channel field positions inside a pixel word: R[29:20] G[19:10] B[9:0]
    localparam int unsigned R_LSB = 20;
    localparam int unsigned G_LSB = 10;
    localparam int unsigned B_LSB = 0;

    // Significant 8 bits sit at the top of each 10-bit channel
    localparam int unsigned R_SIG_LSB = R_LSB + (CH_W - SIG_W);
    localparam int unsigned G_SIG_LSB = G_LSB + (CH_W - SIG_W);
    localparam int unsigned B_SIG_LSB = B_LSB + (CH_W - SIG_W);

    typedef struct packed {
        logic [CH_W-1:0] r;
        logic [CH_W-1:0] g;
        logic [CH_W-1:0] b;
    } pixel_t;

    // Frame-position sideband carried alongside each pixel
    typedef struct packed {
        logic sof;
        logic eol;
    } beat_tag_t;

    // Build a pixel word from three 8-bit channel values
    function automatic pixel_t pack_rgb8(input logic [SIG_W-1:0] r,
                                         input logic [SIG_W-1:0] g,
                                         input logic [SIG_W-1:0] b);
        pixel_t p;
        p.r = {r, 2'b00};
        p.g = {g, 2'b00};
        p.b = {b, 2'b00};
        return p;
    endfunction

endpackage

// File: rtl/dstream_skid.sv
// Two-entry skid buffer for a valid/ready stream link.
// Ports:
//   clk, rst_n                     clock, async active-low reset
//   in_data, in_valid, in_ready    upstream side; in_ready is registered (buffer not full)
//   out_data, out_valid, out_ready downstream side; out_data/out_valid are registers
// The head register drives the output directly; the skid register holds a second
// beat so in_ready never depends combinationally on out_ready.
module dstream_skid #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [W-1:0] out_data,
    output logic         out_valid,
    input  logic         out_ready
);

    logic [1:0]   count_q, count_n;
    logic [W-1:0] head_q, head_n;
    logic [W-1:0] skid_q, skid_n;
    logic         valid_q;
    logic         ready_q;
    logic         push;
    logic         pop;

    assign push = in_valid & ready_q;
    assign pop  = valid_q & out_ready;

    // Occupancy and data movement; push cannot occur at count 2 since ready_q is low
    always_comb begin
        count_n = count_q;
        head_n  = head_q;
        skid_n  = skid_q;
        if (pop) begin
            if (count_q == 2'd2) begin
                head_n  = skid_q;
                count_n = 2'd1;
            end else if (push) begin
                head_n = in_data;
            end else begin
                // Clear the head when draining so stale sideband never shows
                head_n  = '0;
                count_n = 2'd0;
            end
        end else if (push) begin
            if (count_q == 2'd0) begin
                head_n  = in_data;
                count_n = 2'd1;
            end else begin
                skid_n  = in_data;
                count_n = 2'd2;
            end
        end
    end

    // State registers; valid/ready are registered copies of the next occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= 2'd0;
            head_q  <= '0;
            skid_q  <= '0;
            valid_q <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            count_q <= count_n;
            head_q  <= head_n;
            skid_q  <= skid_n;
            valid_q <= (count_n != 2'd0);
            ready_q <= (count_n != 2'd2);
        end
    end

    assign in_ready  = ready_q;
    assign out_data  = head_q;
    assign out_valid = valid_q;

endmodule

// File: rtl/conv_border_mask.sv
// Masks the K-1 pixel border left invalid by the convolution window and tags the
// stream with start-of-frame / end-of-line markers.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   x_data, x_valid, x_ready   filtered pixel stream in (x_ready registered)
//   y_data, y_valid, y_ready   masked pixel stream out (registered)
//   mask_en                    1 = replace border pixels with border_colour
//   border_colour              replacement pixel value
//   sof, eol                   first pixel of frame / last pixel of line, with y_valid
//   frame_count                completed frames, wraps at 16 bits
module conv_border_mask
    import conv_pkg::*;
#(
    parameter int unsigned W      = PIX_W,
    parameter int unsigned WIDTH  = FRAME_WIDTH,
    parameter int unsigned HEIGHT = FRAME_HEIGHT,
    parameter int unsigned K      = KERNEL_K
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] x_data,
    input  logic         x_valid,
    output logic         x_ready,
    output logic [W-1:0] y_data,
    output logic         y_valid,
    input  logic         y_ready,
    input  logic         mask_en,
    input  logic [W-1:0] border_colour,
    output logic         sof,
    output logic         eol,
    output logic [15:0]  frame_count
);

    localparam int unsigned COL_W  = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
    localparam int unsigned ROW_W  = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam int unsigned BORDER = K - 1;

    logic [COL_W-1:0] col_q, col_n;
    logic [ROW_W-1:0] row_q, row_n;
    logic [15:0]      fc_q, fc_n;
    logic             accept;
    logic             last_col;
    logic             last_row;
    logic             border;
    beat_tag_t        in_tag;
    beat_tag_t        out_tag;
    logic [W-1:0]     store_data;
    logic [W+1:0]     out_beat;

    assign accept   = x_valid & x_ready;
    assign last_col = (col_q == COL_W'(WIDTH - 1));
    assign last_row = (row_q == ROW_W'(HEIGHT - 1));
    // Compare at 32 bits so a border wider than the counter cannot truncate
    assign border   = (32'(col_q) < BORDER) || (32'(row_q) < BORDER);

    assign in_tag.sof = (col_q == '0) && (row_q == '0);
    assign in_tag.eol = last_col;
    assign store_data = (mask_en && border) ? border_colour : x_data;

    // Position counters advance only on accepted beats
    always_comb begin
        col_n = col_q;
        row_n = row_q;
        fc_n  = fc_q;
        if (accept) begin
            if (last_col) begin
                col_n = '0;
                if (last_row) begin
                    row_n = '0;
                    fc_n  = fc_q + 16'd1;
                end else begin
                    row_n = row_q + ROW_W'(1);
                end
            end else begin
                col_n = col_q + COL_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q <= '0;
            row_q <= '0;
            fc_q  <= 16'd0;
        end else begin
            col_q <= col_n;
            row_q <= row_n;
            fc_q  <= fc_n;
        end
    end

    // Tags ride in the buffer alongside the pixel so they stay aligned on y
    dstream_skid #(
        .W (W + 2)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   ({in_tag, store_data}),
        .in_valid  (x_valid),
        .in_ready  (x_ready),
        .out_data  (out_beat),
        .out_valid (y_valid),
        .out_ready (y_ready)
    );

    assign out_tag     = beat_tag_t'(out_beat[W+1:W]);
    assign y_data      = out_beat[W-1:0];
    assign sof         = out_tag.sof;
    assign eol         = out_tag.eol;
    assign frame_count = fc_q;

endmodule

// File: tb/tb_conv_border_mask.sv
// Bench for conv_border_mask on a small 8x6 frame with a 5x5 kernel.
module tb_conv_border_mask;

    localparam int unsigned W      = 30;
    localparam int unsigned WIDTH  = 8;
    localparam int unsigned HEIGHT = 6;
    localparam int unsigned K      = 5;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] x_data = '0;
    logic         x_valid = 1'b0;
    logic         x_ready;
    logic [W-1:0] y_data;
    logic         y_valid;
    logic         y_ready = 1'b0;
    logic         mask_en = 1'b0;
    logic [W-1:0] border_colour = '0;
    logic         sof;
    logic         eol;
    logic [15:0]  frame_count;

    conv_border_mask #(
        .W      (W),
        .WIDTH  (WIDTH),
        .HEIGHT (HEIGHT),
        .K      (K)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .x_data        (x_data),
        .x_valid       (x_valid),
        .x_ready       (x_ready),
        .y_data        (y_data),
        .y_valid       (y_valid),
        .y_ready       (y_ready),
        .mask_en       (mask_en),
        .border_colour (border_colour),
        .sof           (sof),
        .eol           (eol),
        .frame_count   (frame_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] data;
        logic         sof;
        logic         eol;
        logic [31:0]  cyc;
    } exp_t;

    typedef struct {
        logic [1:0]   men;     // bit0: mask_en value, bit1: randomise mask_en per cycle
        logic [W-1:0] bc;
        int unsigned  vpct;
        int unsigned  rpct;
        int unsigned  nbeats;
        logic         lat;
        logic [15:0]  exp_fc;
    } scen_t;

    exp_t         sb[$];
    exp_t         mon_e;
    scen_t        scen[4];
    int unsigned  errors = 0;
    int unsigned  checks = 0;
    int unsigned  acc_cnt = 0;
    int unsigned  cyc_cnt = 0;
    int unsigned  m_col = 0;
    int unsigned  m_row = 0;
    logic [15:0]  m_fc = 16'd0;
    logic [31:0]  data_base = 32'd0;
    logic         lat_chk = 1'b0;
    logic         mon_border;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: model the beat on acceptance, compare when it is emitted
    always @(negedge clk) begin
        if (rst_n) begin
            cyc_cnt++;
            if (!y_valid) chk("idle_tags", 64'({sof, eol}), 64'd0);
            if (y_valid && y_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_beat", 64'(y_data), 64'hDEAD);
                end else begin
                    mon_e = sb.pop_front();
                    chk("y_data", 64'(y_data), 64'(mon_e.data));
                    chk("sof", 64'(sof), 64'(mon_e.sof));
                    chk("eol", 64'(eol), 64'(mon_e.eol));
                    if (lat_chk) chk("latency", 64'(cyc_cnt), 64'(mon_e.cyc + 32'd1));
                end
            end
            if (x_valid && x_ready) begin
                mon_border = (m_col < K - 1) || (m_row < K - 1);
                mon_e.data = (mask_en && mon_border) ? border_colour : x_data;
                mon_e.sof  = (m_col == 0) && (m_row == 0);
                mon_e.eol  = (m_col == WIDTH - 1);
                mon_e.cyc  = cyc_cnt;
                sb.push_back(mon_e);
                acc_cnt++;
                if (m_col == WIDTH - 1) begin
                    m_col = 0;
                    if (m_row == HEIGHT - 1) begin
                        m_row = 0;
                        m_fc  = m_fc + 16'd1;
                    end else begin
                        m_row++;
                    end
                end else begin
                    m_col++;
                end
            end
        end
    end

    task automatic do_reset();
        rst_n   = 1'b0;
        #1;
        sb.delete();
        acc_cnt = 0;
        m_col   = 0;
        m_row   = 0;
        m_fc    = 16'd0;
        x_valid = 1'b0;
        y_ready = 1'b0;
        chk("rst_y_valid", 64'(y_valid), 64'd0);
        chk("rst_x_ready", 64'(x_ready), 64'd0);
        chk("rst_sof_eol", 64'({sof, eol}), 64'd0);
        chk("rst_y_data", 64'(y_data), 64'd0);
        chk("rst_frame_count", 64'(frame_count), 64'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("x_ready_after_reset", 64'(x_ready), 64'd1);
    endtask

    task automatic drain();
        int unsigned g = 0;
        x_valid = 1'b0;
        y_ready = 1'b1;
        while (sb.size() != 0 && g < 200) begin
            step();
            g++;
        end
        chk("drain_empty", 64'(sb.size()), 64'd0);
        step();
        chk("y_valid_idle", 64'(y_valid), 64'd0);
    endtask

    task automatic run_scen(input scen_t s);
        int unsigned g = 0;
        do_reset();
        mask_en       = s.men[0];
        border_colour = s.bc;
        lat_chk       = s.lat;
        data_base     = 32'd0;
        while (acc_cnt < s.nbeats && g < 5000) begin
            x_valid = ($urandom_range(0, 99) < s.vpct);
            y_ready = ($urandom_range(0, 99) < s.rpct);
            if (s.men[1]) mask_en = 1'($urandom_range(0, 1));
            x_data = W'(acc_cnt + data_base);
            step();
            g++;
        end
        x_valid = 1'b0;
        chk("accepted_beats", 64'(acc_cnt), 64'(s.nbeats));
        drain();
        chk("frame_count", 64'(frame_count), 64'(s.exp_fc));
        chk("frame_count_model", 64'(frame_count), 64'(m_fc));
        lat_chk = 1'b0;
    endtask

    // Output stall: buffer fills after two beats and holds its head steady
    task automatic stall_test();
        logic [W-1:0] held = '0;
        do_reset();
        mask_en       = 1'b0;
        border_colour = '0;
        data_base     = 32'h1234;
        y_ready       = 1'b0;
        x_valid       = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            x_data = W'(acc_cnt + data_base);
            chk("stall_x_ready", 64'(x_ready), 64'(c < 3));
            if (c >= 2) chk("stall_y_valid", 64'(y_valid), 64'd1);
            if (c == 2) held = y_data;
            if (c > 2) chk("stall_hold", 64'(y_data), 64'(held));
            step();
        end
        chk("stall_accepted", 64'(acc_cnt), 64'd2);
        chk("stall_head", 64'(held), 64'h1234);
        drain();
    endtask

    // Reset with two beats buffered at col 3, row 2
    task automatic midframe_reset_test();
        int unsigned g = 0;
        do_reset();
        mask_en       = 1'b1;
        border_colour = 30'h2A55A5A;
        data_base     = 32'h100;
        x_valid       = 1'b1;
        y_ready       = 1'b1;
        while (acc_cnt < 18 && g < 100) begin
            x_data = W'(acc_cnt + data_base);
            step();
            g++;
        end
        y_ready = 1'b0;
        while (acc_cnt < 19 && g < 100) begin
            x_data = W'(acc_cnt + data_base);
            step();
            g++;
        end
        x_data = W'(acc_cnt + data_base);
        step();
        chk("pre_reset_buffered", 64'(sb.size()), 64'd2);
        chk("pre_reset_x_ready", 64'(x_ready), 64'd0);
        chk("pre_reset_pos", 64'({m_col[7:0], m_row[7:0]}), 64'h0302);
        do_reset();
        x_valid = 1'b1;
        y_ready = 1'b1;
        g = 0;
        while (!y_valid && g < 20) begin
            x_data = W'(acc_cnt + data_base);
            step();
            g++;
        end
        chk("post_reset_y_valid", 64'(y_valid), 64'd1);
        chk("post_reset_sof", 64'(sof), 64'd1);
        chk("post_reset_masked", 64'(y_data), 64'(border_colour));
        while (acc_cnt < 12 && g < 100) begin
            x_data = W'(acc_cnt + data_base);
            step();
            g++;
        end
        drain();
    endtask

    initial begin
        scen[0] = '{2'b01, 30'h0,        100, 100,  48, 1'b1, 16'd1};
        scen[1] = '{2'b00, 30'h0,        100, 100,  48, 1'b1, 16'd1};
        scen[2] = '{2'b01, 30'h3FFFFFFF,  50,  50, 144, 1'b0, 16'd3};
        scen[3] = '{2'b10, 30'h15555555,  70,  40,  96, 1'b0, 16'd2};
        for (int i = 0; i < 4; i++) run_scen(scen[i]);
        stall_test();
        midframe_reset_test();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/conv_border_mask.md
CONV_BORDER_MASK -- requirements
Module: conv_border_mask

Interface
REQ-001 Parameter W, default 30: pixel width, packed R[29:20] G[19:10] B[9:0], 8 significant bits per channel at [29:22]/[19:12]/[9:2].
REQ-002 Parameter WIDTH, default 320: pixels per line.
REQ-003 Parameter HEIGHT, default 240: lines per frame.
REQ-004 Parameter K, default 5: convolution kernel side; sets the masked border width of K-1 pixels.
REQ-005 clk  input  1: single clock; all state updates on its rising edge.
REQ-006 rst_n  input  1: reset, asynchronous assert, active-low.
REQ-007 x  dstream.in  W: filtered pixel stream from conv_filter (data, valid, ready).
REQ-008 y  dstream.out  W: masked pixel stream to the display/VGA stage.
REQ-009 mask_en  input  1: 1 = replace border pixels with border_colour; 0 = pass through.
REQ-010 border_colour  input  W: replacement pixel value.
REQ-011 sof  output  1: high alongside y.valid for the frame's first pixel (col 0, row 0).
REQ-012 eol  output  1: high alongside y.valid for each line's last pixel (col WIDTH-1).
REQ-013 frame_count  output  16: count of completed frames, wraps 65535->0.

Function
REQ-014 A beat is accepted when x.valid & x.ready in a cycle; a beat is emitted when y.valid & y.ready in a cycle.
REQ-015 Buffering: 2-entry skid buffer; x.ready is registered and equals "buffer not full"; x.ready never depends combinationally on y.ready.
REQ-016 Latency: accepted beat appears on y the next cycle when buffer was empty; beats leave strictly in acceptance order; no beat dropped or duplicated.
REQ-017 Counters col (0..WIDTH-1) and row (0..HEIGHT-1) advance only on accepted beats; they tag the accepted beat.
REQ-018 col wraps WIDTH-1 -> 0 and increments row; at col=WIDTH-1, row=HEIGHT-1 both wrap to 0 and frame_count increments on that same accepted beat.
REQ-019 Beat is a border beat when col < K-1 or row < K-1 (window straddled a line/frame wrap).
REQ-020 Stored data = border_colour if mask_en & border, else x.data; mask_en and border_colour sampled at acceptance.
REQ-021 sof and eol are stored with each beat and travel with it through the buffer; valid only while y.valid=1, 0 otherwise.
REQ-022 y.data, sof, eol hold stable while y.valid=1 and y.ready=0.
REQ-023 Full buffer with y.ready=1: one beat leaves; x.ready rises the next cycle.
REQ-024 Buffer with 1 entry, simultaneous accept and emit: occupancy stays 1.
REQ-025 x.valid low mid-line: counters hold; resumption continues from stored position.

Reset
REQ-026 While rst_n=0: y.valid=0, x.ready=0, sof=0, eol=0, y.data=0, col=0, row=0, frame_count=0, buffer empty.
REQ-027 First cycle after rst_n rises: x.ready=1.
REQ-028 Reset mid-frame discards buffered beats; the next accepted beat is tagged col 0, row 0.

Structure
REQ-029 WIDTH, HEIGHT, K defaults and the R/G/B bit-field positions are in shared package conv_pkg, also used by conv_filter.
REQ-030 The skid buffer is sub-module dstream_skid (parameter W+2: data plus sof/eol), reusable on any dstream link.
REQ-031 Counter and mask logic is in conv_border_mask; no multipliers or division.

Verification
REQ-032 WIDTH=8, HEIGHT=6, K=5, mask_en=1, border_colour=0, y.ready=1, 48 beats of data=index -> indices with col<4 or row<4 output 0; others unchanged; sof on beat 0; eol on beats 7,15,...,47; frame_count=1.
REQ-033 Same stream, mask_en=0 -> all 48 values pass unchanged, 1-cycle latency.
REQ-034 y.ready=0 for 5 cycles with x.valid=1 -> exactly 2 beats accepted, x.ready=0 from cycle 3; y.data stable; after y.ready=1 all beats emitted in order.
REQ-035 Random x.valid/y.ready at 50% each over 3 frames -> output equals golden model; frame_count=3.
REQ-036 rst_n pulled low at col 3, row 2 with 2 beats buffered -> y.valid=0 immediately; next accepted beat carries sof=1 and is masked.
